// File: rtl/bus_dispatcher.sv
// Row-bus dispatcher: queues (op, tag, data) commands and drives them onto the shared caster bus in order.
// Define DISPATCH_TIMEOUT_EN to bound READ_WAIT to BUS_TIMEOUT cycles and flag expiry on rsp_err.
module bus_dispatcher #(
    parameter int DATA_WIDTH  = 16,
    parameter int NUM_COL     = 4,
    parameter int FIFO_DEPTH  = 4,
    parameter int BUS_TIMEOUT = 64,
    localparam int TAG_W      = (NUM_COL > 1) ? $clog2(NUM_COL) : 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_op,
    input  logic [TAG_W-1:0]      cmd_tag,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    output logic                  bus_en,
    output logic                  bus_ready,
    output logic [TAG_W-1:0]      bus_tag,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    input  logic [NUM_COL-1:0]    col_valid,
    input  logic [DATA_WIDTH-1:0] bus_rdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, WRITE, READ_WAIT, READ_HOLD} state_t;

    state_t                  state, state_nxt;
    logic                    fifo_op   [FIFO_DEPTH];
    logic [TAG_W-1:0]        fifo_tag  [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]   fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr, rd_ptr;
    logic [CNT_W-1:0]        count;
    logic                    push, pop;
    logic                    head_op;
    logic [TAG_W-1:0]        head_tag;
    logic [DATA_WIDTH-1:0]   head_data;
    logic                    col_hit, tmo_expired;
    logic                    bus_en_nxt, bus_ready_nxt, rsp_valid_nxt;
    logic [TAG_W-1:0]        bus_tag_nxt;
    logic [DATA_WIDTH-1:0]   bus_wdata_nxt, rsp_data_nxt;

    // Tags beyond the last caster are legal to enqueue but never reach the bus.
    function automatic logic tag_in_range(input logic [TAG_W-1:0] t);
        tag_in_range = 1'b0;
        for (int i = 0; i < NUM_COL; i++)
            if (t == TAG_W'(i))
                tag_in_range = 1'b1;
    endfunction

    assign cmd_ready = (count != CNT_W'(FIFO_DEPTH));
    assign push      = cmd_valid && cmd_ready;
    assign head_op   = fifo_op[rd_ptr];
    assign head_tag  = fifo_tag[rd_ptr];
    assign head_data = fifo_data[rd_ptr];
    assign col_hit   = col_valid[bus_tag];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_op[wr_ptr]   <= cmd_op;
            fifo_tag[wr_ptr]  <= cmd_tag;
            fifo_data[wr_ptr] <= cmd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef DISPATCH_TIMEOUT_EN
    localparam int TMO_W = $clog2(BUS_TIMEOUT + 1);
    logic [TMO_W-1:0] tmo_cnt;

    assign tmo_expired = (tmo_cnt == TMO_W'(BUS_TIMEOUT - 1));

    // A response arriving on the expiry cycle takes priority, so rsp_err stays low then.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            tmo_cnt <= '0;
            rsp_err <= 1'b0;
        end else begin
            tmo_cnt <= (state == READ_WAIT) ? tmo_cnt + TMO_W'(1) : '0;
            if (state == READ_WAIT && !col_hit && tmo_expired)
                rsp_err <= 1'b1;
            else if (rsp_valid && rsp_ready)
                rsp_err <= 1'b0;
        end
    end
`else
    assign tmo_expired = 1'b0;
    assign rsp_err     = 1'b0;
`endif

    always_comb begin
        state_nxt     = state;
        pop           = 1'b0;
        bus_en_nxt    = bus_en;
        bus_ready_nxt = 1'b0;
        bus_tag_nxt   = bus_tag;
        bus_wdata_nxt = bus_wdata;
        rsp_valid_nxt = rsp_valid;
        rsp_data_nxt  = rsp_data;
        case (state)
            IDLE, WRITE: begin
                state_nxt  = IDLE;
                bus_en_nxt = 1'b0;
                if (count != '0) begin
                    pop = 1'b1;
                    if (tag_in_range(head_tag)) begin
                        bus_en_nxt    = 1'b1;
                        bus_tag_nxt   = head_tag;
                        bus_wdata_nxt = head_data;
                        if (head_op) begin
                            state_nxt = READ_WAIT;
                        end else begin
                            state_nxt     = WRITE;
                            bus_ready_nxt = 1'b1;
                        end
                    end
                end
            end
            READ_WAIT: begin
                if (col_hit || tmo_expired) begin
                    bus_en_nxt    = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    rsp_data_nxt  = col_hit ? bus_rdata : '0;
                    state_nxt     = READ_HOLD;
                end
            end
            READ_HOLD: begin
                if (rsp_ready) begin
                    rsp_valid_nxt = 1'b0;
                    state_nxt     = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= IDLE;
            bus_en    <= 1'b0;
            bus_ready <= 1'b0;
            bus_tag   <= '0;
            bus_wdata <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            state     <= state_nxt;
            bus_en    <= bus_en_nxt;
            bus_ready <= bus_ready_nxt;
            bus_tag   <= bus_tag_nxt;
            bus_wdata <= bus_wdata_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_data  <= rsp_data_nxt;
        end
    end

endmodule

// File: tb/tb_bus_dispatcher.sv
// Testbench for bus_dispatcher: directed steps plus a randomized phase scored against an in-order command queue.
// The timeout step only runs when DISPATCH_TIMEOUT_EN is defined.
module tb_bus_dispatcher;

    localparam int DW = 16;
    localparam int NC = 4;
    localparam int FD = 4;
    localparam int TW = 2;

    logic          clk = 1'b0;
    logic          rstn;
    logic          cmd_valid, cmd_ready, cmd_op;
    logic [TW-1:0] cmd_tag;
    logic [DW-1:0] cmd_data;
    logic          bus_en, bus_ready;
    logic [TW-1:0] bus_tag;
    logic [DW-1:0] bus_wdata;
    logic [NC-1:0] col_valid;
    logic [DW-1:0] bus_rdata;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;

    bus_dispatcher dut (
        .clk(clk), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_tag(cmd_tag), .cmd_data(cmd_data),
        .bus_en(bus_en), .bus_ready(bus_ready), .bus_tag(bus_tag), .bus_wdata(bus_wdata),
        .col_valid(col_valid), .bus_rdata(bus_rdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          op;
        logic [TW-1:0] tag;
        logic [DW-1:0] data;
    } cmd_t;

    // Reference model: accepted commands must appear on the bus in acceptance order.
    cmd_t          cmd_q[$];
    logic [DW-1:0] rsp_q[$];
    logic          err_q[$];
    int            n_cmp = 0;
    int            n_bad = 0;
    bit            in_read = 1'b0;
    bit            auto_resp = 1'b0;
    logic [TW-1:0] read_tag = '0;
    int            wait_len = 0;

    task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    task automatic respond();
        logic [NC-1:0] mask;
        logic [NC-1:0] noise;
        mask  = NC'(1) << read_tag;
        noise = NC'($urandom);
        bus_rdata = DW'($urandom);
        if (in_read && ($urandom_range(0, 3) == 0 || wait_len >= 20)) begin
            col_valid = noise | mask;
            rsp_q.push_back(bus_rdata);
            err_q.push_back(1'b0);
        end else begin
            col_valid = in_read ? (noise & ~mask) : noise;
        end
    endtask

    task automatic applyStimulus(input logic v, input logic op, input logic [TW-1:0] tag, input logic [DW-1:0] data);
        cmd_valid = v;
        cmd_op    = op;
        cmd_tag   = tag;
        cmd_data  = data;
    endtask

    task automatic tick();
        cmd_t c;
        if (auto_resp)
            respond();
        if (rstn && cmd_valid && cmd_ready) begin
            c.op   = cmd_op;
            c.tag  = cmd_tag;
            c.data = cmd_data;
            cmd_q.push_back(c);
        end
        if (rstn && rsp_valid && rsp_ready) begin
            checkOutput("rsp_expected", 32'(rsp_q.size() > 0), 1);
            if (rsp_q.size() > 0) begin
                checkOutput("rsp_data", 32'(rsp_data), 32'(rsp_q.pop_front()));
                checkOutput("rsp_err", 32'(rsp_err), 32'(err_q.pop_front()));
            end
        end
        @(posedge clk);
        #1;
        if (in_read)
            wait_len++;
        if (!rstn) begin
            in_read = 1'b0;
        end else begin
            if (bus_en && (bus_ready || !in_read)) begin
                checkOutput("bus_expected", 32'(cmd_q.size() > 0), 1);
                if (cmd_q.size() > 0) begin
                    c = cmd_q.pop_front();
                    checkOutput("bus_op", 32'(!bus_ready), 32'(c.op));
                    checkOutput("bus_tag", 32'(bus_tag), 32'(c.tag));
                    if (!c.op)
                        checkOutput("bus_wdata", 32'(bus_wdata), 32'(c.data));
                    read_tag = c.tag;
                    wait_len = 0;
                end
            end
            in_read = bus_en && !bus_ready;
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((cmd_q.size() != 0 || in_read || rsp_valid) && n < budget) begin
            tick();
            n++;
        end
        checkOutput("drain_done", 32'(n < budget), 1);
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not reach its end");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  n;
        int  cnt;
        bit  pushed;
        rstn      = 1'b0;
        col_valid = '0;
        bus_rdata = '0;
        rsp_ready = 1'b0;
        applyStimulus(1'b0, 1'b0, '0, '0);

        // Reset values
        tick();
        tick();
        checkOutput("rst_bus_en", 32'(bus_en), 0);
        checkOutput("rst_bus_ready", 32'(bus_ready), 0);
        checkOutput("rst_bus_tag", 32'(bus_tag), 0);
        checkOutput("rst_bus_wdata", 32'(bus_wdata), 0);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 0);
        checkOutput("rst_rsp_data", 32'(rsp_data), 0);
        checkOutput("rst_rsp_err", 32'(rsp_err), 0);
        checkOutput("rst_cmd_ready", 32'(cmd_ready), 1);
        rstn = 1'b1;
        tick();

        // Single write: on the bus two cycles after being presented, for one cycle
        applyStimulus(1'b1, 1'b0, 2'd2, 16'h1234);
        tick();
        applyStimulus(1'b0, 1'b0, '0, '0);
        checkOutput("wr1_not_yet", 32'(bus_en), 0);
        tick();
        checkOutput("wr1_en", 32'(bus_en), 1);
        checkOutput("wr1_ready", 32'(bus_ready), 1);
        checkOutput("wr1_tag", 32'(bus_tag), 2);
        checkOutput("wr1_wdata", 32'(bus_wdata), 32'h1234);
        tick();
        checkOutput("wr1_one_cycle", 32'(bus_en), 0);

        // Four back-to-back writes
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, TW'(i), DW'($urandom));
            tick();
            if (i == 0) begin
                checkOutput("b2b_first_idle", 32'(bus_en), 0);
            end else begin
                checkOutput("b2b_en", 32'(bus_en && bus_ready), 1);
                checkOutput("b2b_tag", 32'(bus_tag), 32'(i - 1));
            end
        end
        applyStimulus(1'b0, 1'b0, '0, '0);
        tick();
        checkOutput("b2b_last_en", 32'(bus_en && bus_ready), 1);
        checkOutput("b2b_last_tag", 32'(bus_tag), 3);
        tick();
        checkOutput("b2b_done", 32'(bus_en), 0);

        // Read with late response and a stalled consumer
        applyStimulus(1'b1, 1'b1, 2'd1, DW'($urandom));
        tick();
        applyStimulus(1'b0, 1'b0, '0, '0);
        tick();
        checkOutput("rd_en", 32'(bus_en), 1);
        checkOutput("rd_ready_low", 32'(bus_ready), 0);
        checkOutput("rd_tag", 32'(bus_tag), 1);
        col_valid = 4'b1101;
        bus_rdata = 16'h0F0F;
        repeat (4) begin
            tick();
            checkOutput("rd_wait_en", 32'(bus_en), 1);
            checkOutput("rd_wait_no_rsp", 32'(rsp_valid), 0);
        end
        col_valid = 4'b0010;
        bus_rdata = 16'hBEEF;
        rsp_q.push_back(16'hBEEF);
        err_q.push_back(1'b0);
        tick();
        col_valid = '0;
        bus_rdata = 16'h5555;
        checkOutput("rd_rsp_valid", 32'(rsp_valid), 1);
        checkOutput("rd_rsp_data", 32'(rsp_data), 32'hBEEF);
        checkOutput("rd_bus_drop", 32'(bus_en), 0);
        applyStimulus(1'b1, 1'b0, 2'd3, 16'h5A5A);
        tick();
        applyStimulus(1'b0, 1'b0, '0, '0);
        repeat (3) begin
            checkOutput("hold_valid", 32'(rsp_valid), 1);
            checkOutput("hold_data", 32'(rsp_data), 32'hBEEF);
            checkOutput("hold_no_issue", 32'(bus_en), 0);
            if (rsp_valid && rsp_data == 16'hBEEF && !bus_en)
                break;
        end
        tick();
        checkOutput("hold_valid2", 32'(rsp_valid), 1);
        tick();
        checkOutput("hold_valid3", 32'(rsp_valid), 1);
        checkOutput("hold_data3", 32'(rsp_data), 32'hBEEF);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checkOutput("hs_valid_clear", 32'(rsp_valid), 0);
        checkOutput("hs_no_bypass", 32'(bus_en), 0);
        tick();
        checkOutput("after_hs_wr_en", 32'(bus_en && bus_ready), 1);
        checkOutput("after_hs_wr_tag", 32'(bus_tag), 3);
        tick();

        // FIFO fills while a read is stalled; the fifth command waits
        applyStimulus(1'b1, 1'b1, 2'd0, DW'($urandom));
        tick();
        for (int i = 0; i < FD; i++) begin
            checkOutput("ovf_ready_before", 32'(cmd_ready), 1);
            applyStimulus(1'b1, 1'b0, TW'(i), DW'($urandom));
            tick();
        end
        checkOutput("ovf_full", 32'(cmd_ready), 0);
        applyStimulus(1'b1, 1'b0, 2'd2, 16'hC0DE);
        repeat (3) begin
            tick();
            checkOutput("ovf_held", 32'(cmd_ready), 0);
        end
        col_valid = 4'b0001;
        bus_rdata = 16'h7777;
        rsp_q.push_back(16'h7777);
        err_q.push_back(1'b0);
        tick();
        col_valid = '0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        n = 0;
        while (cmd_valid && n < 10) begin
            pushed = cmd_ready;
            tick();
            if (pushed)
                applyStimulus(1'b0, 1'b0, '0, '0);
            n++;
        end
        checkOutput("ovf_fifth_accepted", 32'(cmd_valid), 0);
        applyStimulus(1'b0, 1'b0, '0, '0);
        drain(50);
        checkOutput("ovf_none_lost", 32'(cmd_q.size()), 0);

        // Randomized traffic with a random-latency responder
        auto_resp = 1'b1;
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom), 1'($urandom), TW'($urandom), DW'($urandom));
            rsp_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        applyStimulus(1'b0, 1'b0, '0, '0);
        rsp_ready = 1'b1;
        drain(500);
        auto_resp = 1'b0;
        col_valid = '0;
        rsp_ready = 1'b0;
        tick();
        checkOutput("rand_cmd_q_empty", 32'(cmd_q.size()), 0);
        checkOutput("rand_rsp_q_empty", 32'(rsp_q.size()), 0);

`ifdef DISPATCH_TIMEOUT_EN
        // Read that never gets an answer
        applyStimulus(1'b1, 1'b1, 2'd3, DW'($urandom));
        tick();
        applyStimulus(1'b0, 1'b0, '0, '0);
        n = 0;
        cnt = 0;
        while (!rsp_valid && n < 300) begin
            tick();
            if (bus_en)
                cnt++;
            n++;
        end
        checkOutput("tmo_wait_cycles", 32'(cnt), 64);
        checkOutput("tmo_rsp_valid", 32'(rsp_valid), 1);
        checkOutput("tmo_rsp_err", 32'(rsp_err), 1);
        checkOutput("tmo_rsp_data", 32'(rsp_data), 0);
        rsp_q.push_back('0);
        err_q.push_back(1'b1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checkOutput("tmo_err_clear", 32'(rsp_err), 0);
        checkOutput("tmo_valid_clear", 32'(rsp_valid), 0);
`endif

        // Reset in the middle of a read with commands still queued
        applyStimulus(1'b1, 1'b1, 2'd2, DW'($urandom));
        tick();
        applyStimulus(1'b1, 1'b0, 2'd1, DW'($urandom));
        tick();
        applyStimulus(1'b1, 1'b0, 2'd0, DW'($urandom));
        tick();
        applyStimulus(1'b0, 1'b0, '0, '0);
        checkOutput("mid_rd_en", 32'(bus_en && !bus_ready), 1);
        rstn = 1'b0;
        tick();
        checkOutput("mid_rst_bus_en", 32'(bus_en), 0);
        checkOutput("mid_rst_rsp_valid", 32'(rsp_valid), 0);
        checkOutput("mid_rst_cmd_ready", 32'(cmd_ready), 1);
        rstn = 1'b1;
        cmd_q.delete();
        rsp_q.delete();
        err_q.delete();
        repeat (5) begin
            tick();
            checkOutput("mid_rst_fifo_empty", 32'(bus_en), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
